// File: rtl/parity_check_receiver_pkg.sv
// Shared ALU constants and types for the parity-checking result receiver.
// Holds the word/opcode/instruction widths and the FIFO entry layout.
package parity_check_receiver_pkg;

    localparam int OP_W    = 3;
    localparam int DATA_W  = 4;
    localparam int INSTR_W = 8;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [INSTR_W-1:0] instr;
        logic               perr;
    } entry_t;

    // The sender uses odd parity: data plus parity bit must hold an odd number of ones.
    function automatic logic parity_error(input logic [DATA_W-1:0] data, input logic parity);
        return parity != ~(^data);
    endfunction

endpackage

// File: rtl/parity_check_receiver_op_decoder.sv
// 3-to-8 one-hot opcode decoder, the inverse of the ALU opcode encoder.
module op_decoder
    import parity_check_receiver_pkg::*;
(
    input  logic [OP_W-1:0]    op,
    output logic [INSTR_W-1:0] instr
);

    always_comb begin
        instr     = '0;
        instr[op] = 1'b1;
    end

endmodule

// File: rtl/parity_check_receiver.sv
// Receives ALU result words, checks parity, decodes the opcode and queues
// {data, instr, perr} in a small FIFO; counts parity failures with saturation.
module parity_check_receiver
    import parity_check_receiver_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     parity_in,
    input  logic [OP_W-1:0]          op_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        data_out,
    output logic [INSTR_W-1:0]       instr_out,
    output logic                     perr_out,
    output logic [CNT_W-1:0]         err_count,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] ERR_MAX = '1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic [CNT_W-1:0] err_q,    err_d;

    entry_t             mem_q [DEPTH];
    entry_t             entry_in;
    entry_t             head;
    logic [INSTR_W-1:0] instr_dec;
    logic               push;
    logic               pop;

    op_decoder u_op_decoder (
        .op    (op_in),
        .instr (instr_dec)
    );

    always_comb begin
        entry_in.data  = data_in;
        entry_in.instr = instr_dec;
        entry_in.perr  = parity_error(data_in, parity_in);
    end

    // A full FIFO refuses new words even when the head is leaving this cycle.
    assign in_ready  = (count_q < FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (push && entry_in.perr && (err_q != ERR_MAX)) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Storage is not reset; a stray write during reset is harmless because the pointers restart.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry_in;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign data_out   = head.data;
    assign instr_out  = head.instr;
    assign perr_out   = head.perr;
    assign err_count  = err_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_parity_check_receiver.sv
// Scoreboard bench for parity_check_receiver: expected entries are queued when
// a word is offered and compared against the FIFO head as it is drained.
module tb_parity_check_receiver;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] data_in;
    logic       parity_in;
    logic [2:0] op_in;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] data_out;
    logic [7:0] instr_out;
    logic       perr_out;
    logic [7:0] err_count;
    logic [2:0] fifo_count;

    typedef struct {
        logic [3:0] data;
        logic [7:0] instr;
        logic       perr;
    } exp_t;

    exp_t sb[$];
    int   exp_err;
    int   checks;
    int   passed;
    bit   do_push;
    bit   do_pop;

    parity_check_receiver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .parity_in  (parity_in),
        .op_in      (op_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .instr_out  (instr_out),
        .perr_out   (perr_out),
        .err_count  (err_count),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;

    // Reference model: count the ones directly rather than using a reduction operator.
    function automatic exp_t model(input logic [3:0] d, input logic p, input logic [2:0] op);
        exp_t e;
        int   ones;
        ones = int'(p);
        for (int b = 0; b < 4; b++) ones += int'(d[b]);
        e.data  = d;
        e.instr = 8'd1 << op;
        e.perr  = ((ones % 2) == 0);
        return e;
    endfunction

    task automatic set_inputs(input logic v, input logic [3:0] d, input logic p,
                              input logic [2:0] op, input logic r);
        in_valid  = v;
        data_in   = d;
        parity_in = p;
        op_in     = op;
        out_ready = r;
        do_pop    = r && (sb.size() > 0);
        do_push   = v && (sb.size() < DEPTH);
    endtask

    task automatic tick();
        exp_t e;
        exp_t gone;
        e = model(data_in, parity_in, op_in);
        @(posedge clock);
        #1;
        if (reset) begin
            sb.delete();
            exp_err = 0;
        end else begin
            if (do_pop) gone = sb.pop_front();
            if (do_push) begin
                sb.push_back(e);
                if (e.perr && exp_err < 255) exp_err++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_inputs(1'b0, 4'h0, 1'b0, 3'd0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
        checks++; if (fifo_count !== 3'd0) $display("[TB] FAIL reset_fifo_count: got %0d expected 0", fifo_count); else passed++;
        checks++; if (err_count !== 8'd0) $display("[TB] FAIL reset_err_count: got %0d expected 0", err_count); else passed++;
    endtask

    task automatic test_parity();
        logic [3:0] tbl_d [3] = '{4'b0001, 4'b0000, 4'b0000};
        logic       tbl_p [3] = '{1'b0, 1'b0, 1'b1};
        logic [2:0] tbl_o [3] = '{3'b000, 3'b101, 3'b111};
        for (int i = 0; i < 3; i++) begin
            set_inputs(1'b1, tbl_d[i], tbl_p[i], tbl_o[i], 1'b0);
            tick();
            set_inputs(1'b0, 4'h0, 1'b0, 3'd0, 1'b0);
            checks++; if (out_valid !== 1'b1 || sb.size() != 1) $display("[TB] FAIL parity_out_valid[%0d]: got %b expected 1", i, out_valid); else passed++;
            if (sb.size() > 0) begin
                checks++; if (data_out !== sb[0].data) $display("[TB] FAIL parity_data[%0d]: got %b expected %b", i, data_out, sb[0].data); else passed++;
                checks++; if (instr_out !== sb[0].instr) $display("[TB] FAIL parity_instr[%0d]: got %b expected %b", i, instr_out, sb[0].instr); else passed++;
                checks++; if (perr_out !== sb[0].perr) $display("[TB] FAIL parity_perr[%0d]: got %b expected %b", i, perr_out, sb[0].perr); else passed++;
            end
            checks++; if (err_count !== 8'(exp_err)) $display("[TB] FAIL parity_err_count[%0d]: got %0d expected %0d", i, err_count, exp_err); else passed++;
            set_inputs(1'b0, 4'h0, 1'b0, 3'd0, 1'b1);
            tick();
        end
        checks++; if (fifo_count !== 3'd0) $display("[TB] FAIL parity_drained: got %0d expected 0", fifo_count); else passed++;
    endtask

    task automatic test_full();
        logic [3:0] d;
        for (int i = 0; i < 5; i++) begin
            d = 4'(i);
            set_inputs(1'b1, d, ~(^d), 3'(i), 1'b0);
            if (sb.size() > 0) begin
                checks++; if (data_out !== sb[0].data) $display("[TB] FAIL full_head_stable[%0d]: got %h expected %h", i, data_out, sb[0].data); else passed++;
            end
            tick();
            checks++; if (in_ready !== (sb.size() < DEPTH)) $display("[TB] FAIL full_in_ready[%0d]: got %b expected %b", i, in_ready, sb.size() < DEPTH); else passed++;
        end
        checks++; if (fifo_count !== 3'(sb.size())) $display("[TB] FAIL full_count: got %0d expected %0d", fifo_count, sb.size()); else passed++;
        for (int k = 0; k < 4; k++) begin
            set_inputs(1'b0, 4'h0, 1'b0, 3'd0, 1'b1);
            checks++; if (out_valid !== 1'b1) $display("[TB] FAIL full_drain_valid[%0d]: got %b expected 1", k, out_valid); else passed++;
            if (sb.size() > 0) begin
                checks++; if (instr_out !== sb[0].instr) $display("[TB] FAIL full_drain_instr[%0d]: got %b expected %b", k, instr_out, sb[0].instr); else passed++;
                checks++; if (data_out !== sb[0].data) $display("[TB] FAIL full_drain_data[%0d]: got %h expected %h", k, data_out, sb[0].data); else passed++;
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL full_empty: got %b expected 0", out_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] d;
        for (int i = 0; i < 2; i++) begin
            d = 4'($urandom_range(15));
            set_inputs(1'b1, d, 1'($urandom_range(1)), 3'($urandom_range(7)), 1'b0);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            d = 4'($urandom_range(15));
            set_inputs(1'b1, d, 1'($urandom_range(1)), 3'($urandom_range(7)), 1'b1);
            checks++; if (fifo_count !== 3'd2) $display("[TB] FAIL b2b_count[%0d]: got %0d expected 2", i, fifo_count); else passed++;
            if (sb.size() > 0) begin
                checks++; if (data_out !== sb[0].data) $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, data_out, sb[0].data); else passed++;
                checks++; if (instr_out !== sb[0].instr) $display("[TB] FAIL b2b_instr[%0d]: got %b expected %b", i, instr_out, sb[0].instr); else passed++;
                checks++; if (perr_out !== sb[0].perr) $display("[TB] FAIL b2b_perr[%0d]: got %b expected %b", i, perr_out, sb[0].perr); else passed++;
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            set_inputs(1'b0, 4'h0, 1'b0, 3'd0, 1'b1);
            if (sb.size() > 0) begin
                checks++; if (data_out !== sb[0].data) $display("[TB] FAIL b2b_drain_data[%0d]: got %h expected %h", k, data_out, sb[0].data); else passed++;
            end
            tick();
        end
        checks++; if (err_count !== 8'(exp_err)) $display("[TB] FAIL b2b_err_count: got %0d expected %0d", err_count, exp_err); else passed++;
    endtask

    task automatic test_saturate();
        logic [3:0] d;
        test_reset();
        for (int i = 0; i < 260; i++) begin
            d = 4'(i);
            set_inputs(1'b1, d, ^d, 3'(i), 1'b1);
            tick();
            checks++; if (err_count !== 8'(exp_err)) $display("[TB] FAIL sat_err_count[%0d]: got %0d expected %0d", i, err_count, exp_err); else passed++;
        end
        checks++; if (err_count !== 8'd255) $display("[TB] FAIL sat_final: got %0d expected 255", err_count); else passed++;
        set_inputs(1'b0, 4'h0, 1'b0, 3'd0, 1'b1);
        tick();
    endtask

    task automatic test_reset_midstream();
        logic [3:0] d;
        for (int i = 0; i < 3; i++) begin
            d = 4'(i + 5);
            set_inputs(1'b1, d, ~(^d), 3'(i), 1'b0);
            tick();
        end
        checks++; if (fifo_count !== 3'd3) $display("[TB] FAIL mid_pre_count: got %0d expected 3", fifo_count); else passed++;
        set_inputs(1'b1, 4'h0, 1'b0, 3'd6, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_inputs(1'b0, 4'h0, 1'b0, 3'd0, 1'b0);
        checks++; if (fifo_count !== 3'd0) $display("[TB] FAIL mid_fifo_count: got %0d expected 0", fifo_count); else passed++;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_out_valid: got %b expected 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL mid_in_ready: got %b expected 1", in_ready); else passed++;
        checks++; if (err_count !== 8'd0) $display("[TB] FAIL mid_err_count: got %0d expected 0", err_count); else passed++;
        tick();
        checks++; if (fifo_count !== 3'd0) $display("[TB] FAIL mid_discarded: got %0d expected 0", fifo_count); else passed++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks  = 0;
        passed  = 0;
        exp_err = 0;
        test_reset();
        test_parity();
        test_full();
        test_back_to_back();
        test_saturate();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/parity_check_receiver.md
PARITY_CHECK_RECEIVER -- requirements
Module: parity_check_receiver

Interface
REQ-001 SHALL have parameter DEPTH, default 4, result FIFO depth (power of two, at least 2).
REQ-002 SHALL have parameter CNT_W, default 8, width of the parity error counter.
REQ-003 SHALL have port clock  input  1  single clock for all state; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream word present.
REQ-006 SHALL have port in_ready  output  1  receiver can accept a word this cycle.
REQ-007 SHALL have port data_in  input  4  ALU result word.
REQ-008 SHALL have port parity_in  input  1  parity bit sent with data_in.
REQ-009 SHALL have port op_in  input  3  binary opcode that produced data_in.
REQ-010 SHALL have port out_valid  output  1  FIFO head entry valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the head entry.
REQ-012 SHALL have port data_out  output  4  head entry data.
REQ-013 SHALL have port instr_out  output  8  head entry opcode, decoded to one-hot.
REQ-014 SHALL have port perr_out  output  1  head entry parity error flag.
REQ-015 SHALL have port err_count  output  CNT_W  saturating count of accepted words that failed the parity check.
REQ-016 SHALL have port fifo_count  output  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-017 A word is accepted on a rising edge where in_valid and in_ready are both 1; a word is popped on a rising edge where out_valid and out_ready are both 1.
REQ-018 Parity check: a word passes when parity_in equals ~(^data_in), i.e. data_in plus parity_in holds an odd number of ones; otherwise perr = 1.
REQ-019 Decode: instr = 8'b1 << op_in, exactly one bit set (op 3'b000 -> 8'b0000_0001, 3'b111 -> 8'b1000_0000).
REQ-020 Accepted word stores {data_in, instr, perr} into the FIFO tail at the accepting edge; the check and decode are combinational on the inputs.
REQ-021 Latency: a word accepted at edge N into an empty FIFO gives out_valid = 1 with its fields in the cycle after edge N.
REQ-022 in_ready = (fifo_count < DEPTH); when full, the receiver accepts no word, even if a pop happens in the same cycle.
REQ-023 out_valid = (fifo_count != 0); data_out, instr_out and perr_out always come directly from the head entry. Their value is don't-care while out_valid = 0.
REQ-024 Push and pop in the same cycle (FIFO not empty, not full): fifo_count unchanged, order preserved.
REQ-025 Read and write pointers wrap modulo DEPTH; ordering is strictly FIFO.
REQ-026 err_count increments by 1 on each accepted word with perr = 1 and holds at 2^CNT_W-1 (no wrap).
REQ-027 Head entry fields stay stable while out_valid = 1 and out_ready = 0.

Reset
REQ-028 reset = 1 on a rising edge clears fifo_count, both pointers and err_count to 0. As a result out_valid = 0 and in_ready = 1 in the following cycle.
REQ-029 Reset has priority over a simultaneous push or pop; a word in flight when reset is asserted is discarded and not counted.
REQ-030 FIFO storage contents need not be cleared by reset.

Structure
REQ-031 The opcode width (3), data width (4) and instruction width (8) SHALL be defined as constants in the shared ALU package.
REQ-032 The 3-to-8 opcode decoder SHALL be a separate sub-module named op_decoder, the inverse of the existing opcode encoder.

Verification
REQ-033 Reset, then push data 4'b0001 with parity 0 and op 3'b000 -> next cycle out_valid = 1, data_out 0001, instr_out 0000_0001, perr_out 0, err_count 0.
REQ-034 Push data 4'b0000 with parity 0 (bad) -> perr_out 1, err_count 1; then push 4'b0000 with parity 1 -> perr_out 0, err_count stays 1.
REQ-035 Hold out_ready = 0 and push 5 words with ops 0 through 4 -> in_ready = 0 after the 4th push and the 5th word is not accepted; drain -> instr_out 01, 02, 04, 08 in order.
REQ-036 FIFO holding 2 entries, push and pop in the same cycle for 10 cycles -> fifo_count stays 2, output order matches input order across pointer wrap.
REQ-037 Push 260 bad-parity words with downstream always ready -> err_count saturates at 255.
REQ-038 Assert reset with 3 entries queued and in_valid = 1 -> next cycle fifo_count 0, out_valid 0, in_ready 1, err_count 0.
